// File: rtl/param_line_rotator.sv
// param_line_rotator: line-based video scrambler/descrambler.
// Each active line is buffered in one bank of a ping-pong pair and replayed during the
// following line as a cyclic rotation by a per-line cut point (MODE 0 scrambles, MODE 1
// undoes it). Lines captured during vertical blanking, samples beyond the active length
// and lines with a bad length are replayed unrotated.
// Optional feature: define ROTATOR_LEN_CHECK_EN to enable active-line length checking.
module param_line_rotator #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned ACTIVE_LEN = 1440,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned MODE       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] cut_position,
  input  logic              H,
  input  logic              V,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              cut_err,
  output logic              len_err
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam int unsigned AddrW1  = ADDR_W + 1;
  localparam logic [ADDR_W:0] LenW = AddrW1'(ACTIVE_LEN);

  typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

  state_e              state_q, state_d;
  logic                h_q;
  logic                h_fall, h_rise;
  logic                bank_q;
  logic [ADDR_W-1:0]   wr_idx_q;
  logic [ADDR_W-1:0]   cut_q [2];
  logic                vlat_q [2];
  logic                rot_q [2];
  logic [DATA_W-1:0]   mem_q [2][Depth];

  logic                rd_bank;
  logic [ADDR_W:0]     idx_w, cut_w, sum;
  logic                rotate;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   cut_new;
  logic                cut_bad;
  logic                len_ok;

  assign h_fall  = h_q & ~H;
  assign h_rise  = H & ~h_q;
  assign rd_bank = ~bank_q;

  // Previous H level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= 1'b0;
    end else begin
      h_q <= H;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Line-phase next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (h_fall) state_d = StActive;
      StActive: if (h_rise) state_d = StBlank;
      StBlank:  if (h_fall) state_d = StActive;
      default:  state_d = StIdle;
    endcase
  end

  // Cut point captured at line start; out-of-range values fall back to no rotation
  always_comb begin
    cut_bad = ({1'b0, cut_position} >= LenW);
    cut_new = cut_bad ? '0 : cut_position;
  end

`ifdef ROTATOR_LEN_CHECK_EN
  logic [ADDR_W:0] act_cnt_q;
  logic            len_err_q;

  // Count clocks spent in ACTIVE for the line being captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_cnt_q <= '0;
    end else if (h_fall) begin
      act_cnt_q <= '0;
    end else if (state_q == StActive && act_cnt_q != '1) begin
      act_cnt_q <= act_cnt_q + AddrW1'(1);
    end
  end

  // A line is judged only if it was started after reset (not from IDLE)
  assign len_ok = (state_q == StIdle) || (act_cnt_q == LenW);

  // One-clock pulse when a completed line had the wrong length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= h_fall & ~len_ok;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_ok  = 1'b1;
  assign len_err = 1'b0;
`endif

  // Bank select, write pointer and per-bank line attributes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q         <= 1'b0;
      wr_idx_q       <= '0;
      cut_q[0]       <= '0;
      cut_q[1]       <= '0;
      vlat_q[0]      <= 1'b1;
      vlat_q[1]      <= 1'b1;
      rot_q[0]       <= 1'b0;
      rot_q[1]       <= 1'b0;
      cut_err        <= 1'b0;
      data_out_valid <= 1'b0;
    end else if (h_fall) begin
      // New line start wins over saturation: both banks swap roles on this clock
      bank_q          <= ~bank_q;
      wr_idx_q        <= '0;
      cut_q[~bank_q]  <= cut_new;
      vlat_q[~bank_q] <= V;
      rot_q[~bank_q]  <= 1'b1;
      if (state_q != StIdle) begin
        rot_q[bank_q]  <= len_ok;
        data_out_valid <= 1'b1;
      end
      if (cut_bad) cut_err <= 1'b1;
    end else if (state_q != StIdle && wr_idx_q != '1) begin
      wr_idx_q <= wr_idx_q + ADDR_W'(1);
    end
  end

  // Line buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state_q != StIdle) begin
      mem_q[bank_q][wr_idx_q] <= data_in;
    end
  end

  // Rotated read address with conditional wrap instead of a modulo
  always_comb begin
    idx_w = {1'b0, wr_idx_q};
    cut_w = {1'b0, cut_q[rd_bank]};
    if (MODE == 0) begin
      sum = idx_w + cut_w;
    end else begin
      sum = idx_w + LenW - cut_w;
    end
    if (sum >= LenW) sum = sum - LenW;
    rotate  = (idx_w < LenW) && !vlat_q[rd_bank] && rot_q[rd_bank];
    rd_addr = rotate ? sum[ADDR_W-1:0] : wr_idx_q;
  end

  // Registered output from the previous line's bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      data_out <= mem_q[rd_bank][rd_addr];
    end
  end

endmodule

// File: doc/param_line_rotator.md
PARAM_LINE_ROTATOR -- requirements
Module: param_line_rotator

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning sample width in bits.
REQ-002 SHALL have parameter ACTIVE_LEN, default 1440, meaning active samples per line (2 x 720 for 4:2:2).
REQ-003 SHALL have parameter ADDR_W, default 11, meaning buffer address width; buffer depth is 2**ADDR_W, which is always greater than ACTIVE_LEN.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = scramble and 1 = descramble.
REQ-005 SHALL have port clk, input, 1 bit: sample clock, with all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, DATA_W bits: video sample.
REQ-008 SHALL have port cut_position, input, ADDR_W bits: rotation amount, sampled at line start.
REQ-009 SHALL have port H, input, 1 bit: horizontal blanking flag, high during blanking.
REQ-010 SHALL have port V, input, 1 bit: vertical blanking flag, high during blanking.
REQ-011 SHALL have port data_out, output, DATA_W bits: registered output sample.
REQ-012 SHALL have port data_out_valid, output, 1 bit: high once one full line has been buffered.
REQ-013 SHALL have port cut_err, output, 1 bit: sticky flag, set when cut_position >= ACTIVE_LEN is sampled.
REQ-014 SHALL have port len_err, output, 1 bit: one-clk pulse on a line-length mismatch.

Function
REQ-015 SHALL detect line start (H_fall) as the registered previous H being 1 and the current H being 0.
REQ-016 SHALL implement a state machine with states IDLE, ACTIVE and BLANK:
 - IDLE->ACTIVE on H_fall.
 - ACTIVE->BLANK on H rising.
 - BLANK->ACTIVE on H_fall.
 - No buffer writes and no bank toggles occur in IDLE.
REQ-017 SHALL use two banks of 2**ADDR_W samples in ping-pong; on each H_fall the bank select toggles, the write bank becomes the read bank, and write_index restarts at 0.
REQ-018 SHALL write data_in at write_index into the write bank every clk while in ACTIVE or BLANK, incrementing write_index and saturating at 2**ADDR_W-1; samples at the saturated index overwrite.
REQ-019 SHALL latch the following per bank at H_fall: cut value c, the V level, and the rotate-enable flag.
REQ-020 SHALL set c = 0 and set cut_err when cut_position >= ACTIVE_LEN; cut_err clears only on reset.
REQ-021 SHALL compute the read address for a read index i < ACTIVE_LEN with a rotating bank as follows, where L = ACTIVE_LEN and all arithmetic is in ADDR_W+1 bits with conditional subtraction of L (no modulo operator):
 - MODE 0: (i + c) mod L.
 - MODE 1: (i + L - c) mod L.
REQ-022 SHALL use read address i when i >= ACTIVE_LEN, when the bank's latched V = 1, or when rotate-enable = 0 (blanking/ancillary passthrough).
REQ-023 SHALL register data_out = read bank[addr(i)], where i equals the current write_index, so latency is exactly one line plus one clk.
REQ-024 SHALL make MODE 1 applied to MODE 0 output with the same c per line reproduce the original line.
REQ-025 SHALL set data_out_valid on the second H_fall after reset and hold it until reset.
REQ-026 SHALL apply the new line's H_fall to both banks on the same clk when H_fall and write_index saturation coincide.

Reset
REQ-027 SHALL, while reset = 1, force data_out = 0, data_out_valid = 0, cut_err = 0, len_err = 0, bank select = 0, write_index = 0, state = IDLE, latched c = 0, latched V = 1, and rotate-enable = 0.
REQ-028 SHALL, on reset assertion mid-line, abort that line; after release, output is valid only after two H_fall events, and buffer contents are not cleared.

Configuration
REQ-029 SHALL provide macro ROTATOR_LEN_CHECK_EN; when it is defined:
 - The block counts active samples (clks in ACTIVE).
 - At H_fall, a count != ACTIVE_LEN pulses len_err for 1 clk and clears rotate-enable for the completed line's bank, so that line is output unrotated.
REQ-030 SHALL, without ROTATOR_LEN_CHECK_EN, tie len_err to 0, omit the counter, and always set rotate-enable = 1 at H_fall.

Verification
REQ-031 SHALL cover: ACTIVE_LEN=8, ADDR_W=4, MODE 0, c=3, line 0..7 with V=0 -> next line data_out = 3,4,5,6,7,0,1,2.
REQ-032 SHALL cover: MODE 1, c=3, input 3,4,5,6,7,0,1,2 -> output 0..7; also c=0 -> identity.
REQ-033 SHALL cover: cut_position=8 with ACTIVE_LEN=8 -> cut_err=1 (sticky), line output unrotated 0..7.
REQ-034 SHALL cover: V=1 during the captured line -> passthrough; H-blank samples (i>=8) -> passthrough in both modes.
REQ-035 SHALL cover: with ROTATOR_LEN_CHECK_EN, a 7-sample active line -> len_err pulse at the next H_fall and that line output unrotated; without the macro -> len_err stays 0.
REQ-036 SHALL cover: reset pulsed at i=4 mid-line -> all outputs 0 immediately; data_out_valid=1 only after the second subsequent H_fall.
